// File: rtl/core_lock_client.sv
// Lock client: requests a shared resource from a two-core arbiter,
// performs a burst of beats while granted and releases with a req gap.
module core_lock_client #(
  parameter int LEN_W    = 8,
  parameter int WAIT_MAX = 255,
  parameter int GAP      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             grant,
  output logic             req,
  output logic             acc_en,
  output logic [LEN_W-1:0] beat_cnt,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ACCESS,
    S_RELEASE
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(WAIT_MAX - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP - 1);

  state_t           state, state_n;
  logic [LEN_W-1:0] len_q, len_n, beat_n;
  logic [15:0]      wait_q, wait_n;
  logic [15:0]      gap_q, gap_n;
  logic             done_n, timeout_n, req_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      len_q    <= '0;
      beat_cnt <= '0;
      wait_q   <= '0;
      gap_q    <= '0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      req      <= 1'b0;
    end else begin
      state    <= state_n;
      len_q    <= len_n;
      beat_cnt <= beat_n;
      wait_q   <= wait_n;
      gap_q    <= gap_n;
      done     <= done_n;
      timeout  <= timeout_n;
      req      <= req_n;
    end
  end

  always_comb begin
    state_n   = state;
    len_n     = len_q;
    beat_n    = beat_cnt;
    wait_n    = wait_q;
    gap_n     = gap_q;
    done_n    = 1'b0;
    timeout_n = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_n = 1'b1;
          end else begin
            state_n = S_REQ;
            len_n   = len;
            beat_n  = '0;
            wait_n  = '0;
          end
        end
      end
      S_REQ: begin
        if (grant) begin
          state_n = S_ACCESS;
        end else begin
          wait_n = wait_q + 16'd1;
          if (wait_q == WAIT_LAST) begin
            state_n   = S_RELEASE;
            gap_n     = '0;
            timeout_n = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        if (grant) begin
          beat_n = beat_cnt + 1'b1;
          if (beat_cnt == len_q - 1'b1) begin
            state_n = S_RELEASE;
            gap_n   = '0;
            done_n  = 1'b1;
          end
        end else begin
          // lock lost: re-arbitrate, keep progress
          state_n = S_REQ;
          wait_n  = '0;
        end
      end
      S_RELEASE: begin
        if (gap_q == GAP_LAST) state_n = S_IDLE;
        else gap_n = gap_q + 16'd1;
      end
      default: state_n = S_IDLE;
    endcase
    req_n = (state_n == S_REQ) || (state_n == S_ACCESS);
  end

  assign acc_en = (state == S_ACCESS) && grant;
  assign busy   = (state != S_IDLE);

endmodule

// File: tb/tb_core_lock_client.sv
// Bench for core_lock_client: behavioural job model checked every
// cycle, directed scenarios with literal checks, dual-client arbitration.
module tb_core_lock_client;

  localparam int WMAX = 10;
  localparam int GP   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] len;
  logic       grant;
  logic       req, acc_en, busy, done, timeout;
  logic [7:0] beat_cnt;

  logic       start_ab;
  logic [7:0] len_ab;
  logic       grant_a, grant_b;
  logic       req_a, acc_a, busy_a, done_a, to_a;
  logic       req_b, acc_b, busy_b, done_b, to_b;
  logic [7:0] bc_a, bc_b;
  logic       holder;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  core_lock_client #(.LEN_W(8), .WAIT_MAX(WMAX), .GAP(GP)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .grant(grant),
    .req(req), .acc_en(acc_en), .beat_cnt(beat_cnt), .busy(busy),
    .done(done), .timeout(timeout)
  );

  core_lock_client #(.LEN_W(8)) u_a (
    .clk(clk), .rst(rst), .start(start_ab), .len(len_ab),
    .grant(grant_a), .req(req_a), .acc_en(acc_a), .beat_cnt(bc_a),
    .busy(busy_a), .done(done_a), .timeout(to_a)
  );

  core_lock_client #(.LEN_W(8)) u_b (
    .clk(clk), .rst(rst), .start(start_ab), .len(len_ab),
    .grant(grant_b), .req(req_b), .acc_en(acc_b), .beat_cnt(bc_b),
    .busy(busy_b), .done(done_b), .timeout(to_b)
  );

  // two-core lock arbiter: core a holds by default, lock moves only
  // when the holder drops req and the other core is asking
  always @(posedge clk or posedge rst) begin
    if (rst) holder <= 1'b0;
    else if (!holder && !req_a && req_b) holder <= 1'b1;
    else if (holder && !req_b && req_a) holder <= 1'b0;
  end
  assign grant_a = !holder;
  assign grant_b = holder;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // job model: a job owns the lock for beats, waits otherwise,
  // then holds req low for GP cycles
  bit m_job = 0, m_hold = 0, m_done = 0, m_to = 0;
  int m_len = 0, m_beats = 0, m_waited = 0, m_gap = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_job = 0; m_hold = 0; m_done = 0; m_to = 0;
      m_len = 0; m_beats = 0; m_waited = 0; m_gap = 0;
    end else begin
      m_done = 0;
      m_to   = 0;
      if (m_gap > 0) begin
        m_gap--;
      end else if (m_job) begin
        if (!m_hold) begin
          if (grant) m_hold = 1;
          else begin
            m_waited++;
            if (m_waited == WMAX) begin
              m_job = 0; m_gap = GP; m_to = 1;
            end
          end
        end else if (grant) begin
          m_beats++;
          if (m_beats == m_len) begin
            m_job = 0; m_gap = GP; m_done = 1;
          end
        end else begin
          m_hold = 0; m_waited = 0;
        end
      end else if (start) begin
        if (len == 8'd0) m_done = 1;
        else begin
          m_job = 1; m_hold = 0; m_len = int'(len);
          m_beats = 0; m_waited = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("req", req, m_job);
    chk("acc_en", acc_en, m_job && m_hold && grant);
    chk("beat_cnt", beat_cnt, m_beats[7:0]);
    chk("busy", busy, m_job || (m_gap > 0));
    chk("done", done, m_done);
    chk("timeout", timeout, m_to);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int n_req, n_to, n_acc, n_done, n_done_b, n_both;

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; grant = 1'b0;
    start_ab = 1'b0; len_ab = '0;
    #2;
    chk("rst_req", req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_beat", beat_cnt, 0);
    tick; tick;
    rst = 1'b0;
    tick;

    // burst of 4 with grant tied high
    grant = 1'b1; len = 8'd4; start = 1'b1;
    tick; start = 1'b0;
    chk("b4_c1_req", req, 1);
    chk("b4_c1_acc", acc_en, 0);
    tick;
    chk("b4_c2_acc", acc_en, 1);
    chk("b4_c2_beat", beat_cnt, 0);
    tick; tick; tick;
    chk("b4_c5_acc", acc_en, 1);
    chk("b4_c5_beat", beat_cnt, 3);
    tick;
    chk("b4_c6_done", done, 1);
    chk("b4_c6_beat", beat_cnt, 4);
    chk("b4_c6_req", req, 0);
    tick;
    chk("b4_c7_req", req, 0);
    chk("b4_c7_busy", busy, 1);
    chk("b4_c7_done", done, 0);
    tick;
    chk("b4_c8_busy", busy, 0);

    // grant never arrives: timeout after WMAX cycles of req
    grant = 1'b0; len = 8'd3; start = 1'b1;
    tick; start = 1'b0;
    n_req = 0; n_to = 0; n_acc = 0;
    for (int c = 1; c <= 13; c++) begin
      n_req += int'(req);
      n_to  += int'(timeout);
      n_acc += int'(acc_en);
      if (c == 11) chk("to_c11_pulse", timeout, 1);
      tick;
    end
    chk("to_req_cycles", n_req, 10);
    chk("to_pulses", n_to, 1);
    chk("to_acc", n_acc, 0);
    chk("to_beat", beat_cnt, 0);
    chk("to_busy", busy, 0);

    // len 5, lock lost for 3 cycles after beat 2
    grant = 1'b1; len = 8'd5; start = 1'b1;
    tick; start = 1'b0;
    n_acc = 0; n_done = 0;
    for (int c = 1; c <= 16; c++) begin
      grant = !(c >= 4 && c <= 6);
      #1;
      if (c == 6) begin
        chk("lost_beat_hold", beat_cnt, 2);
        chk("lost_acc", acc_en, 0);
      end
      n_acc  += int'(acc_en);
      n_done += int'(done);
      tick;
    end
    chk("lost_beats", n_acc, 5);
    chk("lost_done", n_done, 1);
    chk("lost_final", beat_cnt, 5);

    // zero-length job, then start ignored during access
    grant = 1'b1; len = 8'd0; start = 1'b1;
    tick; start = 1'b0;
    chk("z_done", done, 1);
    chk("z_req", req, 0);
    chk("z_busy", busy, 0);
    tick;
    chk("z_done_off", done, 0);
    len = 8'd3; start = 1'b1;
    tick; start = 1'b0;
    tick; tick;
    len = 8'd7; start = 1'b1;
    tick; start = 1'b0;
    chk("ign_beat", beat_cnt, 2);
    tick;
    chk("ign_done", done, 1);
    chk("ign_final", beat_cnt, 3);
    tick; tick; tick;

    // reset mid-access, then a fresh job of 2
    len = 8'd4; start = 1'b1;
    tick; start = 1'b0;
    tick; tick; tick;
    chk("mr_beat2", beat_cnt, 2);
    chk("mr_acc", acc_en, 1);
    #1 rst = 1'b1;
    #1;
    chk("mr_acc0", acc_en, 0);
    chk("mr_req0", req, 0);
    chk("mr_busy0", busy, 0);
    chk("mr_beat0", beat_cnt, 0);
    chk("mr_done0", done, 0);
    tick;
    rst = 1'b0;
    tick;
    len = 8'd2; start = 1'b1;
    tick; start = 1'b0;
    n_done = 0;
    for (int c = 1; c <= 8; c++) begin
      n_done += int'(done);
      tick;
    end
    chk("mr_new_done", n_done, 1);
    chk("mr_new_beat", beat_cnt, 2);

    // two clients sharing the lock
    len_ab = 8'd3; start_ab = 1'b1;
    tick; start_ab = 1'b0;
    n_acc = 0; n_both = 0; n_done = 0; n_done_b = 0;
    for (int c = 1; c <= 30; c++) begin
      n_acc    += int'(acc_a) + int'(acc_b);
      n_both   += int'(acc_a && acc_b);
      n_done   += int'(done_a);
      n_done_b += int'(done_b);
      tick;
    end
    chk("dual_beats", n_acc, 6);
    chk("dual_overlap", n_both, 0);
    chk("dual_done_a", n_done, 1);
    chk("dual_done_b", n_done_b, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_lock_client.md
CORE_LOCK_CLIENT -- requirements
Module: core_lock_client

Interface
REQ-001 Parameter LEN_W, default 8, width of burst length and beat count.
REQ-002 Parameter WAIT_MAX, default 255, grant-wait cycles before timeout abort (1..2^16-1).
REQ-003 Parameter GAP, default 2, cycles req is held low after a release (>=1).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 start  input  1  one-cycle job request; sampled only in IDLE.
REQ-007 len  input  LEN_W  beats to perform; captured with start.
REQ-008 grant  input  1  lock grant from the two-core arbiter (core_x_out side).
REQ-009 req  output  1  lock request to arbiter (core_x_in side); registered.
REQ-010 acc_en  output  1  shared-resource access strobe, one beat per cycle high.
REQ-011 beat_cnt  output  LEN_W  beats completed in current job.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse, job completed all beats.
REQ-014 timeout  output  1  one-cycle pulse, job aborted waiting for grant.

Function
REQ-015 FSM states IDLE, REQ, ACCESS, RELEASE; state register updates on clk only.
REQ-016 IDLE: start=1 and len!=0 -> REQ next cycle; len latched, beat_cnt and wait counter cleared.
REQ-017 IDLE: start=1 and len=0 -> stay IDLE, done pulses next cycle, req never asserted.
REQ-018 start outside IDLE ignored; no queuing.
REQ-019 req=1 in REQ and ACCESS, 0 in IDLE and RELEASE.
REQ-020 REQ: grant=1 sampled -> ACCESS next cycle; grant high without req (arbiter default holder) never causes access.
REQ-021 REQ: wait counter increments each cycle grant=0; reaching WAIT_MAX -> RELEASE next cycle, timeout pulses 1 cycle, done not asserted.
REQ-022 ACCESS: acc_en = grant (combinational qualifier), 0 in all other states.
REQ-023 ACCESS: each cycle acc_en=1, beat_cnt increments by 1; no wrap, max value len.
REQ-024 ACCESS: acc_en=1 with beat_cnt=len-1 -> RELEASE next cycle, beat_cnt=len, done pulses same cycle as RELEASE entry.
REQ-025 ACCESS: grant=0 (lock lost) -> acc_en=0, beat_cnt holds, return to REQ with wait counter cleared; remaining beats resume after re-grant.
REQ-026 RELEASE: req=0 for exactly GAP cycles, then IDLE; guarantees arbiter sees req low and may pass lock to other core.
REQ-027 beat_cnt holds final value through RELEASE and IDLE until next accepted start.
REQ-028 done and timeout never high together; each high at most one cycle per job.

Reset
REQ-029 rst=1 forces immediately (async) state IDLE, req=0, acc_en=0, busy=0, done=0, timeout=0, beat_cnt=0, wait counter=0, latched len=0.
REQ-030 rst asserted mid-job aborts with no done/timeout pulse; first accepted start after rst deassertion edge behaves as fresh job.

Verification
REQ-031 grant tied 1, start with len=4 -> req high cycle 1, ACCESS cycle 2, acc_en high cycles 2-5, beat_cnt 1,2,3,4, done at cycle 6, req low cycles 6-7, busy low cycle 8.
REQ-032 grant held 0, WAIT_MAX=10, start len=3 -> req high 10 cycles, timeout pulse once, acc_en never high, beat_cnt=0, back to IDLE after GAP.
REQ-033 len=5, grant dropped for 3 cycles after beat 2 -> acc_en low those cycles, beat_cnt holds 2, resumes to 5, done once.
REQ-034 Two instances plus arbiter, both started same cycle with len=3 -> total acc_en beats 6, never both acc_en high same cycle, both done.
REQ-035 start with len=0 -> done next cycle, req stays 0; start during ACCESS -> ignored, beat_cnt unaffected.
REQ-036 rst pulsed during ACCESS at beat 2 -> all outputs 0 asynchronously, no done pulse, next start with len=2 completes normally.
